// File: rtl/stream_merge_rr.sv
`default_nettype none
// ============================================================================
// Module   : stream_merge_rr
// Purpose  : Two-input AXI4-Stream packet merger, round-robin at packet
//            boundaries, with a 2-entry registered skid buffer on the output.
// Revision : 1.0 - initial release
// ============================================================================
module stream_merge_rr #(
    parameter int DATA_W = 512,
    parameter int KEEP_W = DATA_W/8,
    parameter int USER_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              axis_aclk,
    input  logic              mod_rstn,

    input  logic              s_axis_in0_tvalid,
    input  logic [DATA_W-1:0] s_axis_in0_tdata,
    input  logic [KEEP_W-1:0] s_axis_in0_tkeep,
    input  logic              s_axis_in0_tlast,
    input  logic [USER_W-1:0] s_axis_in0_tuser_size,
    input  logic [USER_W-1:0] s_axis_in0_tuser_src,
    input  logic [USER_W-1:0] s_axis_in0_tuser_dst,
    output logic              s_axis_in0_tready,

    input  logic              s_axis_in1_tvalid,
    input  logic [DATA_W-1:0] s_axis_in1_tdata,
    input  logic [KEEP_W-1:0] s_axis_in1_tkeep,
    input  logic              s_axis_in1_tlast,
    input  logic [USER_W-1:0] s_axis_in1_tuser_size,
    input  logic [USER_W-1:0] s_axis_in1_tuser_src,
    input  logic [USER_W-1:0] s_axis_in1_tuser_dst,
    output logic              s_axis_in1_tready,

    output logic              m_axis_out_tvalid,
    output logic [DATA_W-1:0] m_axis_out_tdata,
    output logic [KEEP_W-1:0] m_axis_out_tkeep,
    output logic              m_axis_out_tlast,
    output logic [USER_W-1:0] m_axis_out_tuser_size,
    output logic [USER_W-1:0] m_axis_out_tuser_src,
    output logic [USER_W-1:0] m_axis_out_tuser_dst,
    input  logic              m_axis_out_tready,

    output logic [1:0]        grant,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1
);

    localparam int PAY_W = DATA_W + KEEP_W + 1 + 3*USER_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD0 = 2'd1,
        FWD1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  pkt_cnt0_q, pkt_cnt0_d;
    logic [CNT_W-1:0]  pkt_cnt1_q, pkt_cnt1_d;

    logic              head_vld_q, head_vld_d;
    logic              tail_vld_q, tail_vld_d;
    logic [PAY_W-1:0]  head_q, head_d;
    logic [PAY_W-1:0]  tail_q, tail_d;

    logic [PAY_W-1:0]  w_pay0;
    logic [PAY_W-1:0]  w_pay1;
    logic [PAY_W-1:0]  w_in_pay;
    logic              w_room;
    logic              w_push;
    logic              w_pop;
    logic              w_in_last;

    assign w_pay0 = {s_axis_in0_tdata, s_axis_in0_tkeep, s_axis_in0_tlast,
                     s_axis_in0_tuser_size, s_axis_in0_tuser_src, s_axis_in0_tuser_dst};
    assign w_pay1 = {s_axis_in1_tdata, s_axis_in1_tkeep, s_axis_in1_tlast,
                     s_axis_in1_tuser_size, s_axis_in1_tuser_src, s_axis_in1_tuser_dst};

    assign w_in_pay  = (state_q == FWD1) ? w_pay1 : w_pay0;
    assign w_in_last = (state_q == FWD1) ? s_axis_in1_tlast : s_axis_in0_tlast;

    // A free entry exists whenever the tail slot is empty (tail implies head).
    assign w_room = ~tail_vld_q;

    assign s_axis_in0_tready = (state_q == FWD0) && w_room;
    assign s_axis_in1_tready = (state_q == FWD1) && w_room;

    assign w_push = (s_axis_in0_tvalid && s_axis_in0_tready) ||
                    (s_axis_in1_tvalid && s_axis_in1_tready);
    assign w_pop  = head_vld_q && m_axis_out_tready;

    assign grant    = {state_q == FWD1, state_q == FWD0};
    assign pkt_cnt0 = pkt_cnt0_q;
    assign pkt_cnt1 = pkt_cnt1_q;

    assign m_axis_out_tvalid = head_vld_q;
    assign {m_axis_out_tdata, m_axis_out_tkeep, m_axis_out_tlast,
            m_axis_out_tuser_size, m_axis_out_tuser_src, m_axis_out_tuser_dst} = head_q;

    // Arbitration FSM: one IDLE bubble per packet, lock held until tlast handshake.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        pkt_cnt0_d = pkt_cnt0_q;
        pkt_cnt1_d = pkt_cnt1_q;
        case (state_q)
            IDLE: begin
                if (s_axis_in0_tvalid && s_axis_in1_tvalid) begin
                    state_d = rr_ptr_q ? FWD1 : FWD0;
                end else if (s_axis_in0_tvalid) begin
                    state_d = FWD0;
                end else if (s_axis_in1_tvalid) begin
                    state_d = FWD1;
                end
            end
            FWD0: begin
                if (w_push && w_in_last) begin
                    state_d    = IDLE;
                    rr_ptr_d   = 1'b1;
                    pkt_cnt0_d = pkt_cnt0_q + CNT_W'(1);
                end
            end
            FWD1: begin
                if (w_push && w_in_last) begin
                    state_d    = IDLE;
                    rr_ptr_d   = 1'b0;
                    pkt_cnt1_d = pkt_cnt1_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Skid buffer: head drives the output, tail catches the beat that arrives
    // while the head is stalled. The tail is only ever filled behind a valid head.
    always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
        tail_d     = tail_q;
        tail_vld_d = tail_vld_q;
        if (!head_vld_q || w_pop) begin
            if (tail_vld_q) begin
                head_d     = tail_q;
                head_vld_d = 1'b1;
                tail_vld_d = w_push;
                if (w_push) begin
                    tail_d = w_in_pay;
                end
            end else if (w_push) begin
                head_d     = w_in_pay;
                head_vld_d = 1'b1;
            end else begin
                head_vld_d = 1'b0;
            end
        end else if (w_push) begin
            tail_d     = w_in_pay;
            tail_vld_d = 1'b1;
        end
    end

    always_ff @(posedge axis_aclk or negedge mod_rstn) begin
        if (!mod_rstn) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            pkt_cnt0_q <= '0;
            pkt_cnt1_q <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            pkt_cnt0_q <= pkt_cnt0_d;
            pkt_cnt1_q <= pkt_cnt1_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_merge_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_merge_rr
// Purpose  : Directed self-checking bench for stream_merge_rr.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_merge_rr;

    localparam int DATA_W = 512;
    localparam int KEEP_W = 64;
    localparam int USER_W = 16;
    localparam int CNT_W  = 32;

    logic              clk;
    logic              mod_rstn;
    logic              in0_tvalid, in1_tvalid;
    logic [DATA_W-1:0] in0_tdata, in1_tdata;
    logic [KEEP_W-1:0] in0_tkeep, in1_tkeep;
    logic              in0_tlast, in1_tlast;
    logic [USER_W-1:0] in0_size, in0_src, in0_dst;
    logic [USER_W-1:0] in1_size, in1_src, in1_dst;
    logic              in0_tready, in1_tready;
    logic              m_tvalid;
    logic [DATA_W-1:0] m_tdata;
    logic [KEEP_W-1:0] m_tkeep;
    logic              m_tlast;
    logic [USER_W-1:0] m_size, m_src, m_dst;
    logic              m_tready;
    logic [1:0]        grant;
    logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] cyc = 0;
    int hs0 = 0;
    int hs1 = 0;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic [USER_W-1:0] size;
        logic [USER_W-1:0] src;
        logic [USER_W-1:0] dst;
        logic [31:0]       cyc;
    } beat_t;
    beat_t outq[$];

    stream_merge_rr dut (
        .axis_aclk             (clk),
        .mod_rstn              (mod_rstn),
        .s_axis_in0_tvalid     (in0_tvalid),
        .s_axis_in0_tdata      (in0_tdata),
        .s_axis_in0_tkeep      (in0_tkeep),
        .s_axis_in0_tlast      (in0_tlast),
        .s_axis_in0_tuser_size (in0_size),
        .s_axis_in0_tuser_src  (in0_src),
        .s_axis_in0_tuser_dst  (in0_dst),
        .s_axis_in0_tready     (in0_tready),
        .s_axis_in1_tvalid     (in1_tvalid),
        .s_axis_in1_tdata      (in1_tdata),
        .s_axis_in1_tkeep      (in1_tkeep),
        .s_axis_in1_tlast      (in1_tlast),
        .s_axis_in1_tuser_size (in1_size),
        .s_axis_in1_tuser_src  (in1_src),
        .s_axis_in1_tuser_dst  (in1_dst),
        .s_axis_in1_tready     (in1_tready),
        .m_axis_out_tvalid     (m_tvalid),
        .m_axis_out_tdata      (m_tdata),
        .m_axis_out_tkeep      (m_tkeep),
        .m_axis_out_tlast      (m_tlast),
        .m_axis_out_tuser_size (m_size),
        .m_axis_out_tuser_src  (m_src),
        .m_axis_out_tuser_dst  (m_dst),
        .m_axis_out_tready     (m_tready),
        .grant                 (grant),
        .pkt_cnt0              (pkt_cnt0),
        .pkt_cnt1              (pkt_cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Inputs change at posedge+1, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        if (m_tvalid && m_tready)
            outq.push_back({m_tdata, m_tkeep, m_tlast, m_size, m_src, m_dst, cyc});
        if (in0_tvalid && in0_tready) hs0 <= hs0 + 1;
        if (in1_tvalid && in1_tready) hs1 <= hs1 + 1;
    end

    // Drives beats 0..nsend-1 of an nb-beat packet; data = d0 + step*beat replicated.
    task automatic send(input int p, input int nb, input logic [31:0] d0,
                        input logic [31:0] step, input logic [15:0] size,
                        input int nsend, input int gap_at, input int kz_at);
        logic [31:0]       d;
        logic [KEEP_W-1:0] k;
        logic              l;
        logic              rdy;
        int                guard;
        for (int b = 0; b < nsend; b++) begin
            d = d0 + step * 32'(b);
            k = (b == kz_at) ? '0 : '1;
            l = (b == nb - 1);
            if (p == 0) begin
                in0_tvalid = 1'b1; in0_tdata = {16{d}}; in0_tkeep = k; in0_tlast = l;
                in0_size = size; in0_src = 16'd0; in0_dst = 16'h0D00;
            end else begin
                in1_tvalid = 1'b1; in1_tdata = {16{d}}; in1_tkeep = k; in1_tlast = l;
                in1_size = size; in1_src = 16'd1; in1_dst = 16'h0D01;
            end
            rdy   = 1'b0;
            guard = 0;
            while (!rdy && guard < 200) begin
                @(negedge clk);
                rdy = (p == 0) ? in0_tready : in1_tready;
                guard++;
            end
            if (!rdy) begin
                n_checks++; n_fail++;
                $display("FAIL send_timeout: port %0d beat %0d tready=%0b, required 1", p, b, rdy);
            end
            @(posedge clk); #1;
            if (b == gap_at) begin
                if (p == 0) in0_tvalid = 1'b0; else in1_tvalid = 1'b0;
                repeat (4) @(posedge clk);
                #1;
            end
        end
        if (p == 0) begin in0_tvalid = 1'b0; in0_tlast = 1'b0; end
        else        begin in1_tvalid = 1'b0; in1_tlast = 1'b0; end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (m_tvalid !== 1'b0 || grant !== 2'b00) begin
            n_fail++; $display("FAIL reset_out: tvalid=%0b grant=%b, required 0/00", m_tvalid, grant);
        end
        n_checks++;
        if (in0_tready !== 1'b0 || in1_tready !== 1'b0) begin
            n_fail++; $display("FAIL reset_tready: %0b/%0b, required 0/0", in0_tready, in1_tready);
        end
        mod_rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pkt_cnt0 !== 32'd0 || pkt_cnt1 !== 32'd0) begin
            n_fail++; $display("FAIL reset_cnt: %0d/%0d, required 0/0", pkt_cnt0, pkt_cnt1);
        end
        n_checks++;
        if (m_tdata !== '0 || m_tkeep !== '0 || m_tlast !== 1'b0 || m_size !== '0 || m_src !== '0 || m_dst !== '0) begin
            n_fail++; $display("FAIL reset_payload: tdata[31:0]=%h keep=%h, required all zero", m_tdata[31:0], m_tkeep);
        end
    endtask

    task automatic test_single();
        int          ob;
        logic [31:0] t0;
        logic [31:0] e;
        ob = outq.size();
        @(posedge clk); #1;
        t0 = cyc;
        fork
            send(0, 3, 32'h11, 32'h11, 16'd192, 3, -1, -1);
            begin
                @(negedge clk);
                n_checks++;
                if (grant !== 2'b00) begin
                    n_fail++; $display("FAIL single_bubble_grant: %b, required 00", grant);
                end
                @(negedge clk);
                n_checks++;
                if (grant !== 2'b01) begin
                    n_fail++; $display("FAIL single_grant: %b, required 01", grant);
                end
            end
        join
        for (int k = 0; k < 50 && outq.size() < ob + 3; k++) @(negedge clk);
        n_checks++;
        if (outq.size() < ob + 3) begin
            n_fail++; $display("FAIL single_count: got %0d beats, required 3", outq.size() - ob);
        end else begin
            for (int i = 0; i < 3; i++) begin
                e = 32'h11 * 32'(i + 1);
                n_checks++;
                if (outq[ob+i].data !== {16{e}} || outq[ob+i].last !== (i == 2)) begin
                    n_fail++; $display("FAIL single_beat%0d: data=%h last=%0b, required %h/%0b",
                                       i, outq[ob+i].data[31:0], outq[ob+i].last, e, (i == 2));
                end
                n_checks++;
                if (outq[ob+i].cyc !== t0 + 32'd2 + 32'(i)) begin
                    n_fail++; $display("FAIL single_lat%0d: cycle %0d, required %0d", i, outq[ob+i].cyc - t0, i + 2);
                end
            end
            n_checks++;
            if (outq[ob].size !== 16'd192 || outq[ob].src !== 16'd0 || outq[ob].dst !== 16'h0D00) begin
                n_fail++; $display("FAIL single_user: size=%0d src=%0d dst=%h, required 192/0/0d00",
                                   outq[ob].size, outq[ob].src, outq[ob].dst);
            end
        end
        n_checks++;
        if (pkt_cnt0 !== 32'd1) begin
            n_fail++; $display("FAIL single_cnt0: %0d, required 1", pkt_cnt0);
        end
    endtask

    task automatic test_contention();
        int          ob;
        logic [31:0] exp_d [8];
        exp_d = '{32'h100, 32'h101, 32'h200, 32'h201, 32'h110, 32'h111, 32'h210, 32'h211};
        @(posedge clk); #1;
        mod_rstn = 1'b0;
        ob = outq.size();
        fork
            begin
                send(0, 2, 32'h100, 32'd1, 16'd128, 2, -1, -1);
                send(0, 2, 32'h110, 32'd1, 16'd128, 2, -1, -1);
            end
            begin
                send(1, 2, 32'h200, 32'd1, 16'd128, 2, -1, -1);
                send(1, 2, 32'h210, 32'd1, 16'd128, 2, -1, -1);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                mod_rstn = 1'b1;
            end
        join
        for (int k = 0; k < 50 && outq.size() < ob + 8; k++) @(negedge clk);
        n_checks++;
        if (outq.size() < ob + 8) begin
            n_fail++; $display("FAIL cont_count: got %0d beats, required 8", outq.size() - ob);
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (outq[ob+i].data !== {16{exp_d[i]}} || outq[ob+i].last !== ((i % 2) == 1) ||
                    outq[ob+i].src !== 16'((i / 2) % 2)) begin
                    n_fail++; $display("FAIL cont_beat%0d: data=%h last=%0b src=%0d, required %h/%0b/%0d",
                                       i, outq[ob+i].data[31:0], outq[ob+i].last, outq[ob+i].src,
                                       exp_d[i], ((i % 2) == 1), (i / 2) % 2);
                end
            end
        end
        n_checks++;
        if (pkt_cnt0 !== 32'd2 || pkt_cnt1 !== 32'd2) begin
            n_fail++; $display("FAIL cont_cnt: %0d/%0d, required 2/2", pkt_cnt0, pkt_cnt1);
        end
    endtask

    task automatic test_backpressure();
        int                ob;
        int                b1;
        int                unstable;
        logic              seen;
        logic [DATA_W-1:0] hold;
        @(posedge clk); #1;
        ob = outq.size();
        b1 = hs1;
        unstable = 0;
        seen = 1'b0;
        hold = '0;
        m_tready = 1'b0;
        fork
            send(1, 5, 32'h300, 32'd1, 16'd320, 5, -1, -1);
            begin
                repeat (10) begin
                    @(negedge clk);
                    if (m_tvalid) begin
                        if (!seen) begin seen = 1'b1; hold = m_tdata; end
                        else if (m_tdata !== hold) unstable++;
                    end else if (seen) begin
                        unstable++;
                    end
                end
                n_checks++;
                if (hs1 - b1 !== 2) begin
                    n_fail++; $display("FAIL bp_accepts: %0d beats accepted, required 2", hs1 - b1);
                end
                n_checks++;
                if (in1_tready !== 1'b0 || m_tvalid !== 1'b1) begin
                    n_fail++; $display("FAIL bp_stall: in1_tready=%0b out_tvalid=%0b, required 0/1", in1_tready, m_tvalid);
                end
                n_checks++;
                if (unstable !== 0 || m_tdata !== {16{32'h300}}) begin
                    n_fail++; $display("FAIL bp_hold: %0d changes, head=%h, required 0/00000300", unstable, m_tdata[31:0]);
                end
                @(posedge clk); #1;
                m_tready = 1'b1;
            end
        join
        for (int k = 0; k < 50 && outq.size() < ob + 5; k++) @(negedge clk);
        n_checks++;
        if (outq.size() < ob + 5) begin
            n_fail++; $display("FAIL bp_count: got %0d beats, required 5", outq.size() - ob);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (outq[ob+i].data !== {16{32'h300 + 32'(i)}} || outq[ob+i].last !== (i == 4)) begin
                    n_fail++; $display("FAIL bp_beat%0d: data=%h last=%0b, required %h/%0b",
                                       i, outq[ob+i].data[31:0], outq[ob+i].last, 32'h300 + 32'(i), (i == 4));
                end
            end
        end
    endtask

    task automatic test_lock_hold();
        int          ob;
        int          b0;
        int          lockerr;
        logic [31:0] e;
        @(posedge clk); #1;
        ob = outq.size();
        b0 = hs0;
        lockerr = 0;
        fork
            send(0, 4, 32'h400, 32'd1, 16'd256, 4, 1, 2);
            begin
                repeat (2) @(posedge clk);
                #1;
                send(1, 1, 32'h500, 32'd1, 16'd64, 1, -1, -1);
            end
            begin
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (hs0 - b0 >= 4) break;
                    if (in1_tready !== 1'b0) lockerr++;
                end
            end
        join
        n_checks++;
        if (lockerr !== 0) begin
            n_fail++; $display("FAIL lock_in1_ready: asserted %0d cycles during in0 lock, required 0", lockerr);
        end
        for (int k = 0; k < 50 && outq.size() < ob + 5; k++) @(negedge clk);
        n_checks++;
        if (outq.size() < ob + 5) begin
            n_fail++; $display("FAIL lock_count: got %0d beats, required 5", outq.size() - ob);
        end else begin
            for (int i = 0; i < 5; i++) begin
                e = (i < 4) ? 32'h400 + 32'(i) : 32'h500;
                n_checks++;
                if (outq[ob+i].data !== {16{e}} || outq[ob+i].src !== 16'(i / 4) || outq[ob+i].last !== (i >= 3)) begin
                    n_fail++; $display("FAIL lock_beat%0d: data=%h src=%0d last=%0b, required %h/%0d/%0b",
                                       i, outq[ob+i].data[31:0], outq[ob+i].src, outq[ob+i].last, e, i / 4, (i >= 3));
                end
            end
            n_checks++;
            if (outq[ob+2].keep !== '0 || outq[ob].keep !== '1) begin
                n_fail++; $display("FAIL lock_keep: beat2 keep=%h beat0 keep=%h, required 0/all ones",
                                   outq[ob+2].keep, outq[ob].keep);
            end
        end
        n_checks++;
        if (pkt_cnt0 !== 32'd3 || pkt_cnt1 !== 32'd4) begin
            n_fail++; $display("FAIL lock_cnt: %0d/%0d, required 3/4", pkt_cnt0, pkt_cnt1);
        end
    endtask

    task automatic test_counter_wrap();
        int          ob;
        logic [31:0] t0;
        @(posedge clk); #1;
        force dut.pkt_cnt1_q = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_cnt1_q;
        n_checks++;
        if (pkt_cnt1 !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL wrap_preset: %h, required ffffffff", pkt_cnt1);
        end
        @(posedge clk); #1;
        ob = outq.size();
        t0 = cyc;
        send(1, 1, 32'h600, 32'd1, 16'd64, 1, -1, -1);
        for (int k = 0; k < 20 && outq.size() < ob + 1; k++) @(negedge clk);
        n_checks++;
        if (outq.size() < ob + 1) begin
            n_fail++; $display("FAIL wrap_count: got %0d beats, required 1", outq.size() - ob);
        end else if (outq[ob].cyc !== t0 + 32'd2 || outq[ob].data !== {16{32'h600}} || outq[ob].last !== 1'b1) begin
            n_fail++; $display("FAIL wrap_beat: cycle %0d data=%h last=%0b, required 2/00000600/1",
                               outq[ob].cyc - t0, outq[ob].data[31:0], outq[ob].last);
        end
        @(negedge clk);
        n_checks++;
        if (pkt_cnt1 !== 32'd0 || pkt_cnt0 !== 32'd3 || grant !== 2'b00) begin
            n_fail++; $display("FAIL wrap_cnt: cnt1=%h cnt0=%0d grant=%b, required 0/3/00", pkt_cnt1, pkt_cnt0, grant);
        end
    endtask

    task automatic test_reset_mid_packet();
        int ob;
        int ob2;
        @(posedge clk); #1;
        ob = outq.size();
        send(0, 4, 32'h700, 32'd1, 16'd256, 2, -1, -1);
        n_checks++;
        if (m_tvalid !== 1'b1 || grant !== 2'b01) begin
            n_fail++; $display("FAIL midrst_pre: tvalid=%0b grant=%b, required 1/01", m_tvalid, grant);
        end
        mod_rstn = 1'b0;
        #1;
        n_checks++;
        if (m_tvalid !== 1'b0 || grant !== 2'b00 || m_tdata !== '0) begin
            n_fail++; $display("FAIL midrst_out: tvalid=%0b grant=%b tdata=%h, required 0/00/0",
                               m_tvalid, grant, m_tdata[31:0]);
        end
        n_checks++;
        if (pkt_cnt0 !== 32'd0 || pkt_cnt1 !== 32'd0) begin
            n_fail++; $display("FAIL midrst_cnt: %0d/%0d, required 0/0", pkt_cnt0, pkt_cnt1);
        end
        repeat (2) @(posedge clk);
        #1;
        mod_rstn = 1'b1;
        ob2 = outq.size();
        n_checks++;
        if (ob2 - ob !== 1) begin
            n_fail++; $display("FAIL midrst_trunc: %0d beats of truncated packet out, required 1", ob2 - ob);
        end
        @(posedge clk); #1;
        send(1, 2, 32'h800, 32'd1, 16'd128, 2, -1, -1);
        for (int k = 0; k < 20 && outq.size() < ob2 + 2; k++) @(negedge clk);
        n_checks++;
        if (outq.size() !== ob2 + 2) begin
            n_fail++; $display("FAIL midrst_count: got %0d beats, required 2", outq.size() - ob2);
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (outq[ob2+i].data !== {16{32'h800 + 32'(i)}} || outq[ob2+i].src !== 16'd1 || outq[ob2+i].last !== (i == 1)) begin
                    n_fail++; $display("FAIL midrst_beat%0d: data=%h src=%0d last=%0b, required %h/1/%0b",
                                       i, outq[ob2+i].data[31:0], outq[ob2+i].src, outq[ob2+i].last,
                                       32'h800 + 32'(i), (i == 1));
                end
            end
        end
        n_checks++;
        if (pkt_cnt1 !== 32'd1 || pkt_cnt0 !== 32'd0) begin
            n_fail++; $display("FAIL midrst_cnt_after: %0d/%0d, required 0/1", pkt_cnt0, pkt_cnt1);
        end
    endtask

    initial begin
        mod_rstn   = 1'b0;
        m_tready   = 1'b1;
        in0_tvalid = 1'b0; in0_tdata = '0; in0_tkeep = '0; in0_tlast = 1'b0;
        in0_size   = '0;   in0_src   = '0; in0_dst   = '0;
        in1_tvalid = 1'b0; in1_tdata = '0; in1_tkeep = '0; in1_tlast = 1'b0;
        in1_size   = '0;   in1_src   = '0; in1_dst   = '0;

        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_lock_hold();
        test_counter_wrap();
        test_reset_mid_packet();

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time %0t, required completion earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
